mult_share_sched: RTL

- Scheduler that time-shares one iterative shift-add multiplier (16-bit multiplicand × 8-bit multiplier, one partial-product step per cycle) between several FFT butterfly requesters.
- Arbitrates round-robin, latches operands, sequences B_W add/shift steps, and returns a tagged 16-bit result over a valid/ready handshake.
- Sits between the radix-4 butterfly units and the shared multiply datapath in the audio FFT.

---
 rtl/mult_share_sched.sv | 104 ++++++++++
 1 files changed

// File: rtl/mult_share_sched.sv
// Round-robin scheduler time-sharing one shift-add multiplier (A_W x B_W, one
// partial product per cycle) between N_REQ requesters; tagged result via valid/ready.
module mult_share_sched #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int A_W   = 16,
    parameter int B_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*A_W-1:0] req_a,
    input  logic [N_REQ*B_W-1:0] req_b,
    output logic [N_REQ-1:0]     gnt,
    output logic                 busy,
    output logic                 res_valid,
    output logic [A_W-1:0]       res_data,
    output logic [ID_W-1:0]      res_id,
    input  logic                 res_ready
);
    localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [A_W-1:0]   acc, mcand, acc_step;
    logic [B_W-1:0]   mplier;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  ptr, sel, idx;
    logic             any_req, last_step;

    // Search from ptr upward with wrap; descending loop so the smallest offset wins.
    always_comb begin
        any_req = 1'b0;
        sel     = '0;
        idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + ID_W'(k);
            if (req[idx]) begin
                any_req = 1'b1;
                sel     = idx;
            end
        end
    end

    assign last_step = (cnt == CNT_W'(B_W - 1));
    assign acc_step  = acc + (mplier[0] ? mcand : '0);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)   state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            ptr       <= '0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: if (any_req) begin
                    gnt    <= N_REQ'(1) << sel;
                    mcand  <= req_a[sel*A_W +: A_W];
                    mplier <= req_b[sel*B_W +: B_W];
                    acc    <= '0;
                    cnt    <= '0;
                    res_id <= sel;
                    ptr    <= sel + 1'b1;
                end
                RUN: begin
                    // Fixed B_W steps even once mplier is exhausted.
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        res_data  <= acc_step;
                        res_valid <= 1'b1;
                    end
                end
                DONE: if (res_ready) res_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
